// File: rtl/noise_ctrl_if.sv
// Purpose : bundles the noise control front end's strobes, control data and LFSR-side outputs.
// Latency : none, wires only.
// Backpr. : none; every signal is a one-cycle strobe or a level.
// Ports   : clk_en/wr/wr_data/tone3_out flow master->slave; noise_clk/mode/lfsr_rst flow slave->master.
interface noise_ctrl_if;
    logic       clk_en;     // one-cycle chip prescale tick
    logic       wr;         // noise control register write strobe
    logic [2:0] wr_data;    // [2]=FB, [1:0]=NF
    logic       tone3_out;  // tone channel 3 square level
    logic       noise_clk;  // one-cycle LFSR shift enable
    logic       mode;       // 1 = white-noise feedback
    logic       lfsr_rst;   // one-cycle LFSR seed reload

    modport master (
        output clk_en, wr, wr_data, tone3_out,
        input  noise_clk, mode, lfsr_rst
    );

    modport slave (
        input  clk_en, wr, wr_data, tone3_out,
        output noise_clk, mode, lfsr_rst
    );
endinterface

// File: rtl/noise_ctrl.sv
// Purpose : noise channel control register, LFSR shift-rate divider / tone-3 edge source, reseed pulse.
// Latency : noise_clk and lfsr_rst are registered, 1 cycle after the qualifying tick/edge/write; mode follows ctrl.
// Backpr. : none; a write in the same cycle as a tick or tone-3 edge wins and that shift event is dropped.
// Ports   : clk, rst (sync, active high); bus = noise_ctrl_if.slave (clk_en, wr, wr_data, tone3_out in;
//           noise_clk, mode, lfsr_rst out).
module noise_ctrl #(
    parameter int DIV_BASE = 16,
    parameter int CNT_W    = 7
) (
    input  logic         clk,
    input  logic         rst,
    noise_ctrl_if.slave  bus
);

    localparam logic [1:0] NF_TONE3 = 2'b11;

    logic [2:0]       ctrl_q,      ctrl_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             phase_q,     phase_d;
    logic             tone3_q,     tone3_d;
    logic             noise_clk_q, noise_clk_d;
    logic             lfsr_rst_q,  lfsr_rst_d;

    // Half-period reload value for a shift-rate select. NF=11 is never passed in:
    // in that mode the counter is left untouched.
    function automatic logic [CNT_W-1:0] reload(input logic [1:0] nf);
        logic [CNT_W-1:0] r;
        case (nf)
            2'b00:   r = CNT_W'(DIV_BASE);
            2'b01:   r = CNT_W'(2 * DIV_BASE);
            default: r = CNT_W'(4 * DIV_BASE);
        endcase
        return r;
    endfunction

    always_comb begin
        ctrl_d      = ctrl_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        noise_clk_d = 1'b0;
        lfsr_rst_d  = 1'b0;
        // Track tone 3 every cycle so entering NF=11 never sees a stale rising edge.
        tone3_d     = bus.tone3_out;

        if (bus.wr) begin
            // A write overrides any tick or tone-3 edge arriving in the same cycle.
            ctrl_d     = bus.wr_data;
            phase_d    = 1'b0;
            lfsr_rst_d = 1'b1;
            if (bus.wr_data[1:0] != NF_TONE3) begin
                cnt_d = reload(bus.wr_data[1:0]);
            end
        end else if (ctrl_q[1:0] == NF_TONE3) begin
            noise_clk_d = bus.tone3_out & ~tone3_q;
        end else if (bus.clk_en) begin
            if (cnt_q == CNT_W'(1)) begin
                cnt_d       = reload(ctrl_q[1:0]);
                phase_d     = ~phase_q;
                // Only the 0->1 phase toggle shifts the LFSR: one shift per full period.
                noise_clk_d = ~phase_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q      <= 3'b000;
            cnt_q       <= CNT_W'(DIV_BASE);
            phase_q     <= 1'b0;
            tone3_q     <= 1'b0;
            noise_clk_q <= 1'b0;
            lfsr_rst_q  <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            tone3_q     <= tone3_d;
            noise_clk_q <= noise_clk_d;
            lfsr_rst_q  <= lfsr_rst_d;
        end
    end

    assign bus.noise_clk = noise_clk_q;
    assign bus.lfsr_rst  = lfsr_rst_q;
    assign bus.mode      = ctrl_q[2];

endmodule
